fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, SHALL be the instruction queue depth and the outstanding-request credit limit.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Reset  in  1  SHALL be synchronous and active-high.
REQ-005 NextPC  in  64  SHALL be the redirect target from the next-PC logic.
REQ-006 Redirect  in  1  SHALL, when high, mark a taken branch/jump to NextPC.
REQ-007 IMemReq  out  1  SHALL be the fetch request valid to instruction memory.
REQ-008 IMemAddr  out  64  SHALL be the fetch address, valid while IMemReq=1.
REQ-009 IMemGnt  in  1  SHALL accept the request in any cycle where IMemReq=1 and IMemGnt=1.
REQ-010 IMemRspValid  in  1  SHALL mark return data; responses return in request order, latency >=1 cycle.
REQ-011 IMemRspData  in  32  SHALL be the returned instruction word.
REQ-012 InstValid  out  1  SHALL indicate Instruction/InstPC hold a valid queue head.
REQ-013 Instruction  out  32  SHALL be the queue-head instruction.
REQ-014 InstPC  out  64  SHALL be the address of Instruction.
REQ-015 InstReady  in  1  SHALL pop the queue head when InstValid=1 and InstReady=1.

Function
REQ-016 FetchPC SHALL drive IMemAddr; on grant, FetchPC <= FetchPC+4, modulo 2^64 (wrap 64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-017 IMemReq SHALL be 1 iff Redirect=0 and (outstanding + queue count) < QDEPTH.
REQ-018 Each granted request SHALL push its address into an in-order PC tag FIFO; each response SHALL pop it.
REQ-019 A response with kill count 0 SHALL push {tag PC, IMemRspData} into the queue, visible on outputs the following cycle (1-cycle latency).
REQ-020 Push and pop in the same cycle SHALL both take effect; credit rule guarantees no push when full.
REQ-021 On Redirect=1: FetchPC <= {NextPC[63:2],2'b00}; queue flushed; InstValid=0 next cycle; kill count <= outstanding after this cycle's grant and response.
REQ-022 Responses arriving while kill count >0 SHALL be discarded and decrement kill count.
REQ-023 Redirect and IMemGnt same cycle: IMemReq is 0 by REQ-017, so no grant occurs; first post-redirect request issues the next cycle.
REQ-024 Redirect and response same cycle: response SHALL be discarded, not enqueued.
REQ-025 Redirect and InstReady same cycle: pop is void; flush wins.
REQ-026 Back-to-back Redirects SHALL each retarget; the last one wins.
REQ-027 Response with outstanding=0 SHALL be ignored with no state change.
REQ-028 Steady state with IMemGnt=1, 1-cycle latency, InstReady=1 SHALL sustain one instruction per cycle.

Reset
REQ-029 Reset SHALL set FetchPC=RESET_PC, outstanding=0, kill=0, queue empty, tag FIFO empty.
REQ-030 Reset SHALL force IMemReq=0, InstValid=0, Instruction=0, InstPC=0, IMemAddr=RESET_PC.
REQ-031 Reset mid-operation SHALL abandon in-flight requests; instruction memory is reset concurrently.
REQ-032 The first request SHALL assert in the first cycle after Reset deasserts.

Structure
REQ-033 Shared package SHALL hold PC_W=64, INST_W=32, RESET_PC default, and the instruction queue entry type {pc, inst}.
REQ-034 Sub-module fetch_queue (parameterised depth/width FIFO with flush) SHALL implement both the instruction queue and the tag FIFO.

Verification
REQ-035 Reset, RESET_PC=0, Gnt=1, latency 1, InstReady=1 -> InstPC 0,4,8,12 on consecutive cycles.
REQ-036 InstReady=0 for 5 cycles -> exactly 2 queued (PC 0,4), IMemReq=0, no loss after release.
REQ-037 Redirect with NextPC=0x100 and 2 outstanding -> both stale responses dropped, next InstPC=0x100, then 0x104.
REQ-038 NextPC=0x203 -> IMemAddr=0x200.
REQ-039 FetchPC=64'hFFFF_FFFF_FFFF_FFFC granted -> next IMemAddr=0.
REQ-040 Reset asserted with 2 outstanding and queue full -> InstValid=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared widths, reset default and instruction-queue entry type for the
// instruction fetch unit and its FIFOs.
//   PC_W / INST_W     : address and instruction word widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   iq_entry_t        : instruction queue entry {pc, inst}
//   align_pc()        : clears the two low address bits of a redirect target
package fetch_unit_pkg;

   localparam int PC_W   = 64;
   localparam int INST_W = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h0;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

   localparam int IQ_ENTRY_W = $bits(iq_entry_t);

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return pc & ~PC_W'(3);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Small circular FIFO with synchronous flush. Used both as the in-order PC tag
// FIFO and as the instruction queue.
//   clk_sys    in   clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   flush      in   synchronous flush (empties the FIFO, wins over push/pop)
//   push       in   write push_data (ignored when full unless popping too)
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   head_data  out  current head entry (undefined when count == 0)
//   count      out  number of valid entries
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign do_pop    = pop && (count != '0);
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end: issues sequential fetch requests under a credit
// limit, tags them with their PC in order, enqueues returning instructions and
// discards responses that belong to requests made before a redirect.
//   CLK           in   clock
//   Reset         in   synchronous active-high reset
//   NextPC        in   redirect target
//   Redirect      in   taken branch/jump to NextPC
//   IMemReq       out  fetch request valid
//   IMemAddr      out  fetch address
//   IMemGnt       in   request accepted when IMemReq && IMemGnt
//   IMemRspValid  in   in-order response valid
//   IMemRspData   in   returned instruction word
//   InstValid     out  queue head valid
//   Instruction   out  queue head instruction
//   InstPC        out  queue head address
//   InstReady     in   consumer pops the head
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              QDEPTH   = 2
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [PC_W-1:0]   NextPC,
   input  logic              Redirect,
   output logic              IMemReq,
   output logic [PC_W-1:0]   IMemAddr,
   input  logic              IMemGnt,
   input  logic              IMemRspValid,
   input  logic [INST_W-1:0] IMemRspData,
   output logic              InstValid,
   output logic [INST_W-1:0] Instruction,
   output logic [PC_W-1:0]   InstPC,
   input  logic              InstReady
);

   localparam int CNT_W  = $clog2(QDEPTH + 1);
   localparam int CRED_W = CNT_W + 1;

   logic [PC_W-1:0]   fetch_pc;
   logic [CNT_W-1:0]  kill_cnt;
   logic [CNT_W-1:0]  outs_cnt;
   logic [CNT_W-1:0]  iq_cnt;
   logic [PC_W-1:0]   tag_pc;
   logic [CRED_W-1:0] credit_used;
   logic              grant;
   logic              rsp_accept;
   logic              iq_push;
   logic              iq_pop;
   iq_entry_t         iq_in;
   iq_entry_t         iq_head;

   // Outstanding requests are exactly the entries in the tag FIFO, so a
   // response with nothing outstanding is simply not accepted.
   assign rsp_accept = IMemRspValid && (outs_cnt != '0);
   assign iq_push    = rsp_accept && (kill_cnt == '0) && !Redirect;
   assign iq_pop     = InstValid && InstReady && !Redirect;

   // The slot freed by this cycle's pop is reusable by this cycle's request;
   // that is what lets a 1-cycle memory sustain one instruction per cycle.
   assign credit_used = {1'b0, outs_cnt} + {1'b0, iq_cnt} - {{CNT_W{1'b0}}, iq_pop};
   assign IMemReq     = !Reset && !Redirect && (credit_used < CRED_W'(QDEPTH));
   assign grant       = IMemReq && IMemGnt;
   assign IMemAddr    = Reset ? RESET_PC : fetch_pc;

   assign InstValid   = !Reset && (iq_cnt != '0);
   assign Instruction = InstValid ? iq_head.inst : '0;
   assign InstPC      = InstValid ? iq_head.pc   : '0;

   assign iq_in.pc   = tag_pc;
   assign iq_in.inst = IMemRspData;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         fetch_pc <= RESET_PC;
         kill_cnt <= '0;
      end else begin
         if (Redirect)   fetch_pc <= align_pc(NextPC);
         else if (grant) fetch_pc <= fetch_pc + PC_W'(4);

         // Everything still in flight after this edge is stale.
         if (Redirect)
            kill_cnt <= outs_cnt - CNT_W'(rsp_accept);
         else if (rsp_accept && (kill_cnt != '0))
            kill_cnt <= kill_cnt - CNT_W'(1);
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (PC_W)
   ) u_tag_fifo (
      .clk_sys   (CLK),
      .reset     (Reset),
      .flush     (1'b0),
      .push      (grant),
      .push_data (fetch_pc),
      .pop       (rsp_accept),
      .head_data (tag_pc),
      .count     (outs_cnt)
   );

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (IQ_ENTRY_W)
   ) u_inst_queue (
      .clk_sys   (CLK),
      .reset     (Reset),
      .flush     (Redirect),
      .push      (iq_push),
      .push_data (iq_in),
      .pop       (iq_pop),
      .head_data (iq_head),
      .count     (iq_cnt)
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [63:0] TB_RESET_PC = 64'h0;
   localparam int          QD          = 2;

   logic        CLK;
   logic        Reset;
   logic [63:0] NextPC;
   logic        Redirect;
   logic        IMemReq;
   logic [63:0] IMemAddr;
   logic        IMemGnt;
   logic        IMemRspValid;
   logic [31:0] IMemRspData;
   logic        InstValid;
   logic [31:0] Instruction;
   logic [63:0] InstPC;
   logic        InstReady;

   fetch_unit #(.RESET_PC(TB_RESET_PC), .QDEPTH(QD)) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .NextPC       (NextPC),
      .Redirect     (Redirect),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .IMemGnt      (IMemGnt),
      .IMemRspValid (IMemRspValid),
      .IMemRspData  (IMemRspData),
      .InstValid    (InstValid),
      .Instruction  (Instruction),
      .InstPC       (InstPC),
      .InstReady    (InstReady)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] addr;
      int          epoch;
      int          cyc;
   } req_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   req_t        inflight[$];
   exp_t        exp_q[$];
   logic [63:0] model_pc;
   int          epoch;
   int          cyc_no;
   int          checks;
   int          errors;
   bit          done;

   logic        samp_valid;
   logic        samp_req;
   logic [63:0] samp_pc;
   logic [63:0] samp_addr;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5EED_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, got, req, cyc_no);
      end
   endtask

   // One clock cycle: drive at negedge, sample 1ns later, then advance the model
   // to what the next rising edge does.
   task automatic cycle(input logic rst, input logic redir, input logic [63:0] npc,
                        input logic gnt, input logic rdy, input int rsp_mode);
      int  used;
      int  pop;
      bit  want;
      req_t r;
      @(negedge CLK);
      Reset        = rst;
      Redirect     = redir;
      NextPC       = npc;
      IMemGnt      = gnt;
      InstReady    = rdy;
      IMemRspValid = 1'b0;
      IMemRspData  = '0;
      if (!rst) begin
         if (inflight.size() > 0 && inflight[0].cyc < cyc_no) begin
            want = (rsp_mode == 1) || (rsp_mode == 2 && $urandom_range(9) < 7);
            if (want) begin
               IMemRspValid = 1'b1;
               IMemRspData  = mem_word(inflight[0].addr);
            end
         end else if (inflight.size() == 0 && rsp_mode == 2 && $urandom_range(19) == 0) begin
            IMemRspValid = 1'b1;
            IMemRspData  = $urandom;
         end
      end
      #1;
      samp_valid = InstValid;
      samp_req   = IMemReq;
      samp_pc    = InstPC;
      samp_addr  = IMemAddr;
      if (rst) begin
         check("rst_req",   {63'h0, IMemReq},   64'h0);
         check("rst_valid", {63'h0, InstValid}, 64'h0);
         check("rst_inst",  {32'h0, Instruction}, 64'h0);
         check("rst_pc",    InstPC,   64'h0);
         check("rst_addr",  IMemAddr, TB_RESET_PC);
         inflight.delete();
         exp_q.delete();
         model_pc = TB_RESET_PC;
         epoch++;
      end else begin
         used = inflight.size() + exp_q.size();
         pop  = (exp_q.size() > 0 && rdy && !redir) ? 1 : 0;
         check("inst_valid", {63'h0, InstValid}, {63'h0, exp_q.size() != 0});
         check("fetch_addr", IMemAddr, model_pc);
         if (redir || (used - pop) >= QD)
            check("req_blocked", {63'h0, IMemReq}, 64'h0);
         else if (used < QD)
            check("req_allowed", {63'h0, IMemReq}, 64'h1);
         if (redir) begin
            epoch++;
            exp_q.delete();
         end
         if (IMemRspValid && inflight.size() > 0) begin
            r = inflight.pop_front();
            if (r.epoch == epoch) exp_q.push_back('{r.addr, IMemRspData});
         end
         if (IMemReq && gnt) begin
            inflight.push_back('{model_pc, epoch, cyc_no});
            model_pc = model_pc + 64'd4;
         end
         if (redir) model_pc = {npc[63:2], 2'b00};
      end
      cyc_no++;
   endtask

   task automatic run_until_valid(input int maxc, input string name);
      int n;
      n = 0;
      do begin
         cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1);
         n++;
      end while (!samp_valid && n < maxc);
      check(name, {63'h0, samp_valid}, 64'h1);
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands over an instruction.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge CLK);
         #2;
         if (!done && !Reset && InstValid && InstReady && !Redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected actual pc=%h required=no instruction", InstPC);
            end else begin
               e = exp_q.pop_front();
               check("head_pc",   InstPC, e.pc);
               check("head_inst", {32'h0, Instruction}, {32'h0, e.inst});
            end
         end
      end
   end

   initial begin
      logic [63:0] npc;
      bit          rst;
      bit          redir;
      bit          found;
      checks = 0; errors = 0; done = 0; epoch = 0; cyc_no = 0;
      model_pc = TB_RESET_PC;
      Reset = 1'b1; Redirect = 1'b0; NextPC = '0; IMemGnt = 1'b0;
      IMemRspValid = 1'b0; IMemRspData = '0; InstReady = 1'b0;

      // Streaming: one instruction per cycle.
      cycle(1, 0, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 1, 0);
      check("first_req", {63'h0, IMemReq}, 64'h0);
      cycle(0, 0, 0, 1, 1, 1);
      check("first_req_after_rst", {63'h0, samp_req}, 64'h1);
      cycle(0, 0, 0, 1, 1, 1);
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 0, 1, 1, 1);
         check("stream_pc", samp_valid ? samp_pc : 64'hDEAD_BEEF, 64'(4 * k));
      end

      // Consumer stall: two entries held, no request, then drained in order.
      cycle(1, 0, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 0, 1);
      check("stall_req", {63'h0, samp_req}, 64'h0);
      check("stall_head", samp_valid ? samp_pc : 64'hDEAD_BEEF, 64'h0);
      cycle(0, 0, 0, 1, 1, 1);
      check("release_0", samp_valid ? samp_pc : 64'hDEAD_BEEF, 64'h0);
      cycle(0, 0, 0, 1, 1, 1);
      check("release_4", samp_valid ? samp_pc : 64'hDEAD_BEEF, 64'h4);

      // Redirect with two requests in flight.
      cycle(1, 0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1, 0);
      cycle(0, 1, 64'h100, 1, 1, 0);
      run_until_valid(12, "redir_wait");
      check("redir_pc0", samp_pc, 64'h100);
      cycle(0, 0, 0, 1, 1, 1);
      check("redir_pc1", samp_valid ? samp_pc : 64'hDEAD_BEEF, 64'h104);

      // Misaligned target and back-to-back redirects.
      cycle(0, 1, 64'h203, 1, 1, 1);
      cycle(0, 0, 0, 1, 1, 1);
      check("align_addr", samp_addr, 64'h200);
      cycle(0, 1, 64'h300, 1, 1, 1);
      cycle(0, 1, 64'h407, 1, 1, 1);
      cycle(0, 0, 0, 1, 1, 1);
      check("b2b_redirect", samp_addr, 64'h404);

      // Address wrap.
      cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1);
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         cycle(0, 0, 0, 1, 1, 1);
         if (samp_req && samp_addr == 64'hFFFF_FFFF_FFFF_FFFC) found = 1;
      end
      check("wrap_grant_seen", {63'h0, found}, 64'h1);
      cycle(0, 0, 0, 1, 1, 1);
      check("wrap_addr", samp_addr, 64'h0);

      // Reset with a full queue, then with two requests outstanding.
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 0, 1);
      check("full_before_rst", {63'h0, samp_valid}, 64'h1);
      cycle(1, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 1, 1);
      check("rst_full_valid", {63'h0, samp_valid}, 64'h0);
      check("rst_full_refetch", samp_req ? samp_addr : 64'hDEAD_BEEF, TB_RESET_PC);
      for (int k = 0; k < 2; k++) cycle(0, 0, 0, 1, 1, 0);
      cycle(1, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 1, 1, 1);
      check("rst_outs_refetch", samp_req ? samp_addr : 64'hDEAD_BEEF, TB_RESET_PC);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(199) == 0);
         redir = !rst && ($urandom_range(11) == 0);
         case ($urandom_range(2))
            0:       npc = {$urandom, $urandom};
            1:       npc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(255));
            default: npc = 64'($urandom_range(4095));
         endcase
         cycle(rst, redir, npc, $urandom_range(9) < 7, $urandom_range(9) < 7, 2);
      end

      cycle(0, 0, 0, 0, 0, 0);
      done = 1;
      @(negedge CLK);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
